// File: rtl/glb_result_checker.sv
// Walks a contiguous GLB region, compares each word against a golden stream under a mask,
// counts mismatches (saturating) and captures the first one.
module glb_result_checker #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [DATA_W-1:0] mask_i,
  output logic              glb_re_o,
  output logic [ADDR_W-1:0] glb_addr_o,
  input  logic [DATA_W-1:0] glb_rdata_i,
  output logic              gold_re_o,
  output logic [CNT_W-1:0]  gold_idx_o,
  input  logic [DATA_W-1:0] gold_data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  first_err_idx_o,
  output logic [DATA_W-1:0] first_err_got_o,
  output logic [DATA_W-1:0] first_err_exp_o,
  output logic              first_err_vld_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e              r_state;
  logic [CNT_W-1:0]    r_len;
  logic [DATA_W-1:0]   r_mask;
  logic [CNT_W-1:0]    r_k;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_re;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [CNT_W-1:0]    r_err_cnt;
  logic [CNT_W-1:0]    r_fe_idx;
  logic [DATA_W-1:0]   r_fe_got;
  logic [DATA_W-1:0]   r_fe_exp;
  logic                r_fe_vld;
  logic [RD_LAT-1:0]   r_pipe_vld;
  logic [CNT_W-1:0]    r_pipe_idx [RD_LAT];

  logic                w_abort;
  logic                w_mismatch;
  logic [CNT_W-1:0]    w_cmp_idx;
  logic [CNT_W-1:0]    w_err_nxt;
  logic                w_pipe_empty_nxt;

  assign w_abort    = abort_i && (r_state == StIssue || r_state == StDrain);
  assign w_cmp_idx  = r_pipe_idx[RD_LAT-1];
  assign w_mismatch = r_pipe_vld[RD_LAT-1] && (|((glb_rdata_i ^ gold_data_i) & r_mask));
  assign w_err_nxt  = (w_mismatch && !(&r_err_cnt)) ? r_err_cnt + CNT_W'(1) : r_err_cnt;

  // Pipe is empty after this edge once the last outstanding word is being consumed now.
  always_comb begin
    w_pipe_empty_nxt = !r_re;
    for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
      if (r_pipe_vld[i]) w_pipe_empty_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_mask     <= '0;
      r_k        <= '0;
      r_addr     <= '0;
      r_re       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_fe_idx   <= '0;
      r_fe_got   <= '0;
      r_fe_exp   <= '0;
      r_fe_vld   <= 1'b0;
      r_pipe_vld <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) r_pipe_idx[i] <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_abort) begin
        r_pipe_vld <= '0;
      end else begin
        r_pipe_vld[0] <= r_re;
        r_pipe_idx[0] <= r_k;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
          r_pipe_vld[i] <= r_pipe_vld[i-1];
          r_pipe_idx[i] <= r_pipe_idx[i-1];
        end
        if (w_mismatch) begin
          r_err_cnt <= w_err_nxt;
          if (!r_fe_vld) begin
            r_fe_vld <= 1'b1;
            r_fe_idx <= w_cmp_idx;
            r_fe_got <= glb_rdata_i;
            r_fe_exp <= gold_data_i;
          end
        end
      end

      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_len     <= len_i;
            r_mask    <= mask_i;
            r_addr    <= base_addr_i;
            r_k       <= '0;
            r_err_cnt <= '0;
            r_fe_vld  <= 1'b0;
            r_fe_idx  <= '0;
            r_fe_got  <= '0;
            r_fe_exp  <= '0;
            r_busy    <= 1'b1;
            if (len_i == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= StIssue;
              r_re    <= 1'b1;
              r_pass  <= 1'b0;
            end
          end
        end
        StIssue: begin
          if (w_abort) begin
            r_state <= StIdle;
            r_re    <= 1'b0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (r_k == r_len - CNT_W'(1)) begin
            r_state <= StDrain;
            r_re    <= 1'b0;
          end else begin
            r_k    <= r_k + CNT_W'(1);
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        StDrain: begin
          if (w_abort) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (w_pipe_empty_nxt) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign glb_re_o        = r_re;
  assign gold_re_o       = r_re;
  assign glb_addr_o      = r_addr;
  assign gold_idx_o      = r_k;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign pass_o          = r_pass;
  assign err_cnt_o       = r_err_cnt;
  assign first_err_idx_o = r_fe_idx;
  assign first_err_got_o = r_fe_got;
  assign first_err_exp_o = r_fe_exp;
  assign first_err_vld_o = r_fe_vld;

endmodule
